pps_decode_stall: RTL and testbench
===================================

PPS_DECODE_STALL -- requirements
Module: pps_decode_stall

Interface
REQ-001 Parameter LOAD_LAT, default 1, minimum number of stall cycles per load; legal range 1..16.
REQ-002 Parameter PERF_W, default 16, width of the stall performance counter.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 id_valid  in  1  ID stage holds a valid instruction.
REQ-006 id_mem_load  in  1  ID instruction is a load (mem_op & ~mem_wr).
REQ-007 id_rs, id_rt  in  5 each  source register specifiers.
REQ-008 id_use_rs, id_use_rt  in  1 each  source operand actually read.
REQ-009 id_regwrite  in  1  ID instruction writes the register file.
REQ-010 ex_mem_load  in  1  EX stage holds a load.
REQ-011 ex_rd  in  5  EX destination register.
REQ-012 mem_ready  in  1  data memory has completed the outstanding load.
REQ-013 wb_we, wb_rd, wb_data  in  1/5/32  writeback request, address, data.
REQ-014 rf_rd1, rf_rd2  in  32 each  raw register-file read data for rs and rt.
REQ-015 id_stall  out  1  freeze PC, IF/ID and ID.
REQ-016 id_rs_data, id_rt_data  out  32 each  operand data after bypass.
REQ-017 rf_wen  out  1  gated register-file write enable.
REQ-018 id_regwrite_out  out  1  gated regwrite passed to ID/EX.
REQ-019 stall_cnt  out  PERF_W  count of stalled cycles.

Function
REQ-020 The FSM SHALL have two states, IDLE and WAIT, plus a down-counter cnt of width clog2(LOAD_LAT)+1.
REQ-021 In IDLE, load_req = id_valid & id_mem_load SHALL set id_stall high combinationally in the same cycle; the next state is WAIT with cnt <= LOAD_LAT-1.
REQ-022 In WAIT with cnt != 0, cnt SHALL decrement and id_stall SHALL stay high; mem_ready is ignored.
REQ-023 In WAIT with cnt == 0:
- mem_ready=1: id_stall low that cycle, next state IDLE.
- mem_ready=0: stay in WAIT, stall high; there is no timeout.
REQ-024 A load present in IDLE the cycle after release SHALL retrigger REQ-021, so back-to-back loads each stall LOAD_LAT cycles minimum.
REQ-025 Load-use hazard: hz = ex_mem_load & (ex_rd != 0) & ((id_use_rs & id_rs == ex_rd) | (id_use_rt & id_rt == ex_rd)).
- hz SHALL raise id_stall in any state.
- hz SHALL NOT change the FSM state.
REQ-026 id_stall SHALL be the OR of the FSM stall and hz.
REQ-027 rf_wen = wb_we & (wb_rd != 0) & ~id_stall.
REQ-028 id_regwrite_out = id_valid & id_regwrite & ~id_stall.
REQ-029 stall_cnt SHALL increment on every cycle with id_stall=1 and saturate at all-ones without wrapping.

Reset
REQ-030 While rst=1 at a rising edge: state becomes IDLE, cnt 0, stall_cnt 0.
REQ-031 Reset asserted in WAIT SHALL abandon the wait; id_stall then follows REQ-021/REQ-025 from inputs only.
REQ-032 Outputs have no other registered state.

Configuration
REQ-033 Macro PPS_WB_BYPASS_EN, when defined, SHALL enable WB-to-ID bypass:
- id_rs_data = wb_data if wb_we & wb_rd != 0 & wb_rd == id_rs, else rf_rd1.
- id_rt_data is formed the same way from id_rt and rf_rd2.
- The bypass uses ungated wb_we.
REQ-034 Without PPS_WB_BYPASS_EN, id_rs_data = rf_rd1 and id_rt_data = rf_rd2 directly, and no compare logic SHALL be built.

Verification
REQ-035 LOAD_LAT=1, single load, mem_ready=1 -> id_stall high 1 cycle then low; id_regwrite_out low during stall, high on release; stall_cnt=1.
REQ-036 LOAD_LAT=4, load, mem_ready=1 throughout -> id_stall high exactly 4 cycles; with mem_ready held 0 until cycle 7 -> stall high 7 cycles.
REQ-037 ex_mem_load=1, ex_rd=5, id_rs=5, id_use_rs=1 -> id_stall=1 that cycle, FSM stays IDLE; same with ex_rd=0 -> id_stall=0.
REQ-038 Bypass on: wb_we=1, wb_rd=7, wb_data=32'hDEADBEEF, id_rt=7, rf_rd2=0 -> id_rt_data=32'hDEADBEEF; wb_rd=0 -> id_rt_data=rf_rd2; macro off -> id_rt_data=0.
REQ-039 LOAD_LAT=8, rst pulsed on 3rd WAIT cycle -> next cycle state IDLE, id_stall=0 with no load, stall_cnt=0.
REQ-040 PERF_W=4, hold a load with mem_ready=0 for 20 cycles -> stall_cnt saturates at 4'hF.

Source files
------------

// File: rtl/pps_decode_stall.sv
// Decode-stage stall controller: load-latency FSM, load-use hazard stall, gated writes, stall counter.
// Optional WB-to-ID operand bypass is built only when PPS_WB_BYPASS_EN is defined.
module pps_decode_stall #(
    parameter int LOAD_LAT = 1,
    parameter int PERF_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_mem_load,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_regwrite,
    input  logic              ex_mem_load,
    input  logic [4:0]        ex_rd,
    input  logic              mem_ready,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    input  logic [31:0]       rf_rd1,
    input  logic [31:0]       rf_rd2,
    output logic              id_stall,
    output logic [31:0]       id_rs_data,
    output logic [31:0]       id_rt_data,
    output logic              rf_wen,
    output logic              id_regwrite_out,
    output logic [PERF_W-1:0] stall_cnt
);

    localparam int CNT_W = $clog2(LOAD_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cnt_next;
    logic [PERF_W-1:0] stall_cnt_reg;
    logic              load_req;
    logic              hz;
    logic              fsm_stall;

    assign load_req = id_valid & id_mem_load;

    // Hazard stall is purely combinational and never disturbs the load FSM.
    assign hz = ex_mem_load & (ex_rd != 5'd0) &
                ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (load_req) begin
                    state_next = WAIT;
                    cnt_next   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else if (mem_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // mem_ready only matters once the minimum latency has elapsed.
    always_comb begin
        fsm_stall = 1'b0;
        case (state_reg)
            IDLE:    fsm_stall = load_req;
            WAIT:    fsm_stall = (cnt_reg != '0) | ~mem_ready;
            default: fsm_stall = 1'b0;
        endcase
    end

    assign id_stall        = fsm_stall | hz;
    assign rf_wen          = wb_we & (wb_rd != 5'd0) & ~id_stall;
    assign id_regwrite_out = id_valid & id_regwrite & ~id_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (id_stall && (stall_cnt_reg != {PERF_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + PERF_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_reg;

`ifdef PPS_WB_BYPASS_EN
    logic [4:0]  src_id  [2];
    logic [31:0] rf_data [2];
    logic [31:0] op_data [2];

    assign src_id[0]  = id_rs;
    assign src_id[1]  = id_rt;
    assign rf_data[0] = rf_rd1;
    assign rf_data[1] = rf_rd2;

    // Bypass sees the raw writeback request, even when the RF write is held off.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
            assign op_data[gi] = (wb_we && (wb_rd != 5'd0) && (wb_rd == src_id[gi])) ?
                                 wb_data : rf_data[gi];
        end
    endgenerate

    assign id_rs_data = op_data[0];
    assign id_rt_data = op_data[1];
`else
    logic unused_wb_data;

    assign unused_wb_data = ^wb_data;
    assign id_rs_data     = rf_rd1;
    assign id_rt_data     = rf_rd2;
`endif

endmodule

// File: tb/tb_pps_decode_stall.sv
// Bench for pps_decode_stall: three instances (LOAD_LAT 4/1/8, PERF_W 16/16/4) on shared stimulus.
// Table vectors for hazard/gating/bypass, plus scoreboarded load sequences.
module tb_pps_decode_stall;

    logic        clk;
    logic        rst;
    logic        id_valid, id_mem_load, id_use_rs, id_use_rt, id_regwrite;
    logic [4:0]  id_rs, id_rt, ex_rd, wb_rd;
    logic        ex_mem_load, mem_ready, wb_we;
    logic [31:0] wb_data, rf_rd1, rf_rd2;

    logic [2:0]  stall_w, rego_w, rfwen_w;
    logic [31:0] rs_a, rt_a, rs_b, rt_b, rs_c, rt_c;
    logic [15:0] scnt_a, scnt_b;
    logic [3:0]  scnt_c;

    pps_decode_stall #(.LOAD_LAT(4), .PERF_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_mem_load(id_mem_load),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_regwrite(id_regwrite), .ex_mem_load(ex_mem_load), .ex_rd(ex_rd),
        .mem_ready(mem_ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .id_stall(stall_w[0]), .id_rs_data(rs_a),
        .id_rt_data(rt_a), .rf_wen(rfwen_w[0]), .id_regwrite_out(rego_w[0]),
        .stall_cnt(scnt_a));

    pps_decode_stall #(.LOAD_LAT(1), .PERF_W(16)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_mem_load(id_mem_load),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_regwrite(id_regwrite), .ex_mem_load(ex_mem_load), .ex_rd(ex_rd),
        .mem_ready(mem_ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .id_stall(stall_w[1]), .id_rs_data(rs_b),
        .id_rt_data(rt_b), .rf_wen(rfwen_w[1]), .id_regwrite_out(rego_w[1]),
        .stall_cnt(scnt_b));

    pps_decode_stall #(.LOAD_LAT(8), .PERF_W(4)) dut_c (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_mem_load(id_mem_load),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_regwrite(id_regwrite), .ex_mem_load(ex_mem_load), .ex_rd(ex_rd),
        .mem_ready(mem_ready), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .id_stall(stall_w[2]), .id_rs_data(rs_c),
        .id_rt_data(rt_c), .rf_wen(rfwen_w[2]), .id_regwrite_out(rego_w[2]),
        .stall_cnt(scnt_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef PPS_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [31:0] R1 = 32'h1111_1111;

    typedef struct {
        logic        exl;
        logic [4:0]  exrd, rs, rt;
        logic        urs, urt, wbwe;
        logic [4:0]  wbrd;
        logic [31:0] wbdata, rd2;
        logic        e_stall, e_rfwen, e_rego;
        logic [31:0] e_rt_byp, e_rs_byp;
    } vec_t;

    typedef struct packed {
        logic [2:0]       stall;
        logic [2:0]       rego;
        logic [2:0][15:0] scnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: elapsed cycles since the load was accepted.
    int lat[3]     = '{4, 1, 8};
    int cmax[3]    = '{65535, 65535, 15};
    bit busy[3]    = '{0, 0, 0};
    int elapsed[3] = '{0, 0, 0};
    int mcnt[3]    = '{0, 0, 0};
    int seq_cnt[3] = '{0, 0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] scnt_of(input int i);
        if (i == 0) return scnt_a;
        if (i == 1) return scnt_b;
        return {12'd0, scnt_c};
    endfunction

    // One clock: predict, push, compare at negedge, advance model at posedge.
    task automatic step();
        exp_t e;
        bit   hz, ld, fs;
        hz = ex_mem_load && (ex_rd != 5'd0) &&
             ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
        ld = id_valid && id_mem_load;
        for (int i = 0; i < 3; i++) begin
            fs = busy[i] ? !(elapsed[i] >= lat[i] && mem_ready) : ld;
            e.stall[i] = fs | hz;
            e.rego[i]  = id_valid & id_regwrite & ~(fs | hz);
            e.scnt[i]  = 16'(mcnt[i]);
        end
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall[%0d]", i), 32'(stall_w[i]), 32'(e.stall[i]));
            chk($sformatf("regwrite_out[%0d]", i), 32'(rego_w[i]), 32'(e.rego[i]));
            chk($sformatf("stall_cnt[%0d]", i), 32'(scnt_of(i)), 32'(e.scnt[i]));
            seq_cnt[i] += int'(stall_w[i]);
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                busy[i] = 0; elapsed[i] = 0; mcnt[i] = 0;
            end else begin
                if (e.stall[i] && mcnt[i] < cmax[i]) mcnt[i]++;
                if (!busy[i] && ld) begin
                    busy[i] = 1; elapsed[i] = 1;
                end else if (busy[i]) begin
                    if (elapsed[i] >= lat[i] && mem_ready) busy[i] = 0;
                    else elapsed[i]++;
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 1; id_mem_load = 0; id_use_rs = 0; id_use_rt = 0; id_regwrite = 1;
        id_rs = 0; id_rt = 0; ex_mem_load = 0; ex_rd = 0; mem_ready = 1;
        wb_we = 0; wb_rd = 0; wb_data = 0; rf_rd1 = R1; rf_rd2 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic run(input int n, input int nload, input int rdy_from, input string tag);
        for (int i = 0; i < 3; i++) seq_cnt[i] = 0;
        for (int k = 0; k < n; k++) begin
            id_mem_load = (k < nload);
            mem_ready   = (k >= rdy_from);
            step();
        end
        id_mem_load = 0;
        $display("SEQ %s stall cycles a=%0d b=%0d c=%0d cnt a=%0d b=%0d c=%0d",
                 tag, seq_cnt[0], seq_cnt[1], seq_cnt[2], scnt_a, scnt_b, scnt_c);
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0,
                   1'b1, 1'b0, 1'b0, 32'h0, R1};
        tbl[1] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0,
                   1'b0, 1'b0, 1'b1, 32'h0, R1};
        tbl[2] = '{1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h2222,
                   1'b1, 1'b0, 1'b0, 32'h2222, R1};
        tbl[3] = '{1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h2222,
                   1'b0, 1'b0, 1'b1, 32'h2222, R1};
        tbl[4] = '{1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0,
                   1'b0, 1'b0, 1'b1, 32'h0, R1};
        tbl[5] = '{1'b0, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 32'h0,
                   1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, R1};
        tbl[6] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 32'h2222,
                   1'b0, 1'b0, 1'b1, 32'h2222, R1};
        tbl[7] = '{1'b0, 5'd0, 5'd7, 5'd3, 1'b0, 1'b0, 1'b1, 5'd7, 32'hCAFE_F00D, 32'h33,
                   1'b0, 1'b1, 1'b1, 32'h33, 32'hCAFE_F00D};
        tbl[8] = '{1'b1, 5'd4, 5'd4, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0BAD_C0DE, 32'h55,
                   1'b1, 1'b0, 1'b0, 32'h0BAD_C0DE, R1};
        tbl[9] = '{1'b0, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 5'd7, 32'h1234_5678, 32'h77,
                   1'b0, 1'b0, 1'b1, 32'h77, R1};

        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset stall_cnt a", 32'(scnt_a), 32'd0);
        chk("reset stall_cnt b", 32'(scnt_b), 32'd0);
        chk("reset stall_cnt c", 32'(scnt_c), 32'd0);
        chk("reset id_stall", 32'(stall_w), 32'd0);
        rst = 0;

        // Hazard, write gating and bypass vectors, all with the FSM idle.
        for (int r = 0; r < 10; r++) begin
            ex_mem_load = tbl[r].exl;  ex_rd = tbl[r].exrd;
            id_rs = tbl[r].rs;         id_rt = tbl[r].rt;
            id_use_rs = tbl[r].urs;    id_use_rt = tbl[r].urt;
            wb_we = tbl[r].wbwe;       wb_rd = tbl[r].wbrd;
            wb_data = tbl[r].wbdata;   rf_rd2 = tbl[r].rd2;
            #2;
            chk($sformatf("vec%0d id_stall", r), 32'(stall_w[0]), 32'(tbl[r].e_stall));
            chk($sformatf("vec%0d rf_wen", r), 32'(rfwen_w[0]), 32'(tbl[r].e_rfwen));
            chk($sformatf("vec%0d regwrite_out", r), 32'(rego_w[0]), 32'(tbl[r].e_rego));
            chk($sformatf("vec%0d rt_data", r), rt_a, BYP ? tbl[r].e_rt_byp : tbl[r].rd2);
            chk($sformatf("vec%0d rs_data", r), rs_a, BYP ? tbl[r].e_rs_byp : R1);
            $display("VEC %0d stall=%b rf_wen=%b rego=%b rs=%h rt=%h",
                     r, stall_w[0], rfwen_w[0], rego_w[0], rs_a, rt_a);
            step();
        end

        // Single load, memory ready at once.
        do_reset();
        run(12, 1, 0, "single_ready");
        chk("single stall cycles a", 32'(seq_cnt[0]), 32'd4);
        chk("single stall cycles b", 32'(seq_cnt[1]), 32'd1);
        chk("single stall cycles c", 32'(seq_cnt[2]), 32'd8);
        chk("single stall_cnt b", 32'(scnt_b), 32'd1);
        chk("single stall_cnt a", 32'(scnt_a), 32'd4);

        // Single load, memory late until cycle 7.
        do_reset();
        run(14, 1, 7, "late_ready");
        chk("late stall cycles a", 32'(seq_cnt[0]), 32'd7);
        chk("late stall cycles b", 32'(seq_cnt[1]), 32'd7);
        chk("late stall cycles c", 32'(seq_cnt[2]), 32'd8);

        // Reset while waiting on the 3rd WAIT cycle abandons the wait.
        do_reset();
        mem_ready = 0;
        id_mem_load = 1;
        step();
        id_mem_load = 0;
        step();
        step();
        rst = 1;
        step();
        rst = 0;
        chk("rst_in_wait id_stall c", 32'(stall_w[2]), 32'd0);
        chk("rst_in_wait stall_cnt c", 32'(scnt_c), 32'd0);
        step();
        step();
        $display("SEQ rst_in_wait stall=%b cnt_c=%0d", stall_w, scnt_c);

        // Load held with memory never ready: 4-bit counter saturates.
        do_reset();
        run(20, 20, 1000, "saturate");
        chk("saturate stall_cnt c", 32'(scnt_c), 32'hF);
        chk("saturate stall_cnt a", 32'(scnt_a), 32'd20);

        // Back-to-back loads retrigger the minimum latency each time.
        do_reset();
        run(12, 12, 0, "back_to_back");
        chk("b2b stall cycles a", 32'(seq_cnt[0]), 32'd10);
        chk("b2b stall cycles b", 32'(seq_cnt[1]), 32'd6);
        chk("b2b stall cycles c", 32'(seq_cnt[2]), 32'd11);

        do_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
